// File: rtl/gpio_pkg.sv
// Shared definitions for the byte-lane GPIO controller: register group codes,
// lane arithmetic and parameter legality.
package gpio_pkg;

  localparam logic [3:0] GRP_OUT     = 4'd0;
  localparam logic [3:0] GRP_IN      = 4'd1;
  localparam logic [3:0] GRP_DIR     = 4'd2;
  localparam logic [3:0] GRP_SET     = 4'd3;
  localparam logic [3:0] GRP_CLR     = 4'd4;
  localparam logic [3:0] GRP_RISE_EN = 4'd5;
  localparam logic [3:0] GRP_FALL_EN = 4'd6;
  localparam logic [3:0] GRP_STATUS  = 4'd7;
  localparam logic [3:0] GRP_IRQ_EN  = 4'd8;

  function automatic int lane_cnt(input int w);
    return w / 8;
  endfunction

  function automatic bit params_ok(input int w, input int stages);
    return (w % 8 == 0) && (w >= 8) && (w <= 64) && (stages >= 2) && (stages <= 4);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with a one-deep history flop; reports enabled
// rising/falling edges of the synchronised value.
module gpio_sync_edge #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin_in,
  input  logic [W-1:0] rise_en,
  input  logic [W-1:0] fall_en,
  output logic [W-1:0] in_val,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]             hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin_in};
    hist_d = sync_q[STAGES-1];
  end

  // History resets to 0 alongside the chain, so release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign in_val = sync_q[STAGES-1];
  assign rise   = in_val & ~hist_q & rise_en;
  assign fall   = ~in_val & hist_q & fall_en;

endmodule

// File: rtl/gpio_ctrl_irq.sv
// Byte-lane CPU-bus GPIO controller: OUT/DIR registers with atomic SET/CLR,
// synchronised IN, sticky W1C edge STATUS and a masked level interrupt.
module gpio_ctrl_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cpu_do,
  input  logic [7:0]        cpu_addr,
  output logic [7:0]        cpu_di,
  input  logic              rd,
  input  logic              wr,
  input  logic [GPIO_W-1:0] pin_in,
  output logic [GPIO_W-1:0] pin_out,
  output logic [GPIO_W-1:0] pin_oe,
  output logic              irq
);

  localparam int LANES = lane_cnt(GPIO_W);

  if (!params_ok(GPIO_W, SYNC_STAGES)) begin : g_param_err
    $error("gpio_ctrl_irq: GPIO_W must be 8..64 in steps of 8, SYNC_STAGES 2..4");
  end

  logic [3:0]        grp;
  logic [2:0]        lane;
  logic              lane_ok;
  logic              addr3_unused;
  logic [GPIO_W-1:0] lane_mask, wbits, in_val, rise, fall, rd_word, rd_shift;
  logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d, rise_en_q, rise_en_d;
  logic [GPIO_W-1:0] fall_en_q, fall_en_d, status_q, status_d, irq_en_q, irq_en_d, w1c;
  logic [7:0]        cpu_di_q, cpu_di_d;
  logic              irq_q, irq_d;

  assign grp          = cpu_addr[7:4];
  assign lane         = cpu_addr[2:0];
  assign addr3_unused = cpu_addr[3];
  assign lane_ok      = 32'(lane) < LANES;
  // Out-of-range lanes get an empty mask, so every write path ignores them.
  assign lane_mask    = lane_ok ? (GPIO_W'(8'hFF) << {lane, 3'b000}) : '0;
  assign wbits        = {LANES{cpu_do}} & lane_mask;

  gpio_sync_edge #(.W(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (reset),
    .pin_in  (pin_in),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .in_val  (in_val),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c       = '0;
    if (wr) begin
      case (grp)
        GRP_OUT:     out_d     = (out_q & ~lane_mask) | wbits;
        GRP_DIR:     dir_d     = (dir_q & ~lane_mask) | wbits;
        GRP_SET:     out_d     = out_q | wbits;
        GRP_CLR:     out_d     = out_q & ~wbits;
        GRP_RISE_EN: rise_en_d = (rise_en_q & ~lane_mask) | wbits;
        GRP_FALL_EN: fall_en_d = (fall_en_q & ~lane_mask) | wbits;
        GRP_STATUS:  w1c       = wbits;
        GRP_IRQ_EN:  irq_en_d  = (irq_en_q & ~lane_mask) | wbits;
        default:     ;
      endcase
    end
    // Clear first, then set: a same-cycle edge beats the W1C.
    status_d = (status_q & ~w1c) | rise | fall;
    irq_d    = |(status_d & irq_en_q);

    case (grp)
      GRP_OUT:     rd_word = out_q;
      GRP_IN:      rd_word = in_val;
      GRP_DIR:     rd_word = dir_q;
      GRP_RISE_EN: rd_word = rise_en_q;
      GRP_FALL_EN: rd_word = fall_en_q;
      GRP_STATUS:  rd_word = status_q;
      GRP_IRQ_EN:  rd_word = irq_en_q;
      default:     rd_word = '0;
    endcase
    rd_shift = rd_word >> {lane, 3'b000};
    cpu_di_d = cpu_di_q;
    if (rd) cpu_di_d = lane_ok ? rd_shift[7:0] : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      cpu_di_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      cpu_di_q  <= cpu_di_d;
      irq_q     <= irq_d;
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;
  assign cpu_di  = cpu_di_q;
  assign irq     = irq_q;

endmodule
